// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// A request takes three states: IDLE (grant), ISSUE (capture result) and RESP (hold result until it is consumed).
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int SELW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SELW-1:0]  req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SELW-1:0]  req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SELW-1:0]  alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q;
    logic             last_q;
    logic             owner_q;
    logic [WIDTH-1:0] a_q, b_q, rsp_data_q;
    logic [SELW-1:0]  sel_q;
    logic             rsp0_valid_q, rsp1_valid_q, busy_q;
    logic [15:0]      op_count_q, op_count_d;
    logic             win;
    logic             grant0, grant1, hs;
    logic             owner_rdy;

    // On a tie the requester not granted last wins; win = 1 selects requester 1.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) win = ~last_q;
        else if (req1_valid)          win = 1'b1;
    end

    assign grant0    = (state_q == IDLE) && !rst && req0_valid && !win;
    assign grant1    = (state_q == IDLE) && !rst && req1_valid && win;
    assign hs        = grant0 || grant1;
    assign owner_rdy = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == RESP && owner_rdy) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            rsp_data_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            op_count_q <= op_count_d;
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        a_q     <= win ? req1_a : req0_a;
                        b_q     <= win ? req1_b : req0_b;
                        sel_q   <= win ? req1_sel : req0_sel;
                        owner_q <= win;
                        last_q  <= win;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_data_q   <= alu_res;
                    rsp0_valid_q <= ~owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (owner_rdy) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = busy_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, directed corner sequences and
// random traffic checked against a cycle-counting transaction model.
module tb_alu_share_arbiter;
    localparam int W = 32;
    localparam int S = 4;
    localparam logic [S-1:0] ADD = 4'b1010;
    localparam logic [S-1:0] SUB = 4'b0110;

    logic          clk = 1'b0;
    logic          rst;
    logic          v0, v1, r0, r1, rv0, rv1, rr0, rr1, busy;
    logic [W-1:0]  a0, b0, a1, b1, alu_a, alu_b, alu_res, rsp_data;
    logic [S-1:0]  s0, s1, alu_sel;
    logic [15:0]   op_count;

    alu_share_arbiter #(.WIDTH(W), .SELW(S)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_sel(s0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_sel(s1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .rsp0_valid(rv0), .rsp0_ready(rr0), .rsp1_valid(rv1), .rsp1_ready(rr1),
        .rsp_data(rsp_data), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU stub: add for ADD, subtract for anything else
    assign alu_res = (alu_sel == ADD) ? alu_a + alu_b : alu_a - alu_b;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an operation granted in cycle g shows its response from g+2 until consumed.
    bit            m_busy, m_owner, m_last;
    int            m_g, ncyc;
    logic [W-1:0]  m_a, m_b, m_rspd;
    logic [S-1:0]  m_sel;
    logic [15:0]   m_cnt;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [S-1:0] sel);
        return (sel == ADD) ? a + b : a - b;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_g = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_rspd = '0; m_cnt = '0;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, waits one cycle.
    task automatic step();
        bit idle, e_r0, e_r1, e_resp;
        #1;
        idle   = !m_busy;
        e_r0   = idle && !rst && v0 && (!v1 || m_last);
        e_r1   = idle && !rst && v1 && (!v0 || !m_last);
        e_resp = m_busy && (ncyc >= m_g + 2);
        chk("req0_ready", 32'(r0), 32'(e_r0));
        chk("req1_ready", 32'(r1), 32'(e_r1));
        chk("rsp0_valid", 32'(rv0), 32'(e_resp && !m_owner));
        chk("rsp1_valid", 32'(rv1), 32'(e_resp && m_owner));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rsp_data", rsp_data, m_rspd);
        chk("op_count", 32'(op_count), 32'(m_cnt));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", 32'(alu_sel), 32'(m_sel));
        if (rst) model_reset();
        else if (idle) begin
            if (e_r0 || e_r1) begin
                m_busy = 1'b1; m_g = ncyc; m_owner = e_r1; m_last = e_r1;
                m_a = e_r1 ? a1 : a0; m_b = e_r1 ? b1 : b0; m_sel = e_r1 ? s1 : s0;
            end
        end else if (ncyc == m_g + 1) m_rspd = ref_alu(m_a, m_b, m_sel);
        else if (m_owner ? rr1 : rr0) begin
            m_busy = 1'b0;
            m_cnt  = m_cnt + 16'd1;
        end
        ncyc++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]   in;    // rst, v0, v1, rr0, rr1
        logic [4:0]   ex;    // r0, r1, rv0, rv1, busy
        logic [W-1:0] data;
        logic [15:0]  cnt;
    } vec_t;

    vec_t tbl[11];
    int   grants[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{5'b11111, 5'b00000, 32'd0,  16'd0};
        tbl[1]  = '{5'b01111, 5'b10000, 32'd0,  16'd0};
        tbl[2]  = '{5'b01111, 5'b00001, 32'd0,  16'd0};
        tbl[3]  = '{5'b01111, 5'b00101, 32'd11, 16'd0};
        tbl[4]  = '{5'b01111, 5'b01000, 32'd11, 16'd1};
        tbl[5]  = '{5'b01111, 5'b00001, 32'd11, 16'd1};
        tbl[6]  = '{5'b01111, 5'b00011, 32'd10, 16'd1};
        tbl[7]  = '{5'b01111, 5'b10000, 32'd10, 16'd2};
        tbl[8]  = '{5'b00011, 5'b00001, 32'd10, 16'd2};
        tbl[9]  = '{5'b00011, 5'b00101, 32'd11, 16'd2};
        tbl[10] = '{5'b00011, 5'b00000, 32'd11, 16'd3};

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        a0 = 32'd8; b0 = 32'd3; s0 = ADD; a1 = 32'd5; b1 = 32'd5; s1 = ADD;
        repeat (2) @(negedge clk);
        model_reset();
        ncyc = 0;

        // Tie from reset: req0 first (8+3), then req1 (5+5), then req0 again
        for (int i = 0; i < 11; i++) begin
            {rst, v0, v1, rr0, rr1} = tbl[i].in;
            #1;
            chk($sformatf("tbl%0d ready0", i), 32'(r0), 32'(tbl[i].ex[4]));
            chk($sformatf("tbl%0d ready1", i), 32'(r1), 32'(tbl[i].ex[3]));
            chk($sformatf("tbl%0d rsp0_valid", i), 32'(rv0), 32'(tbl[i].ex[2]));
            chk($sformatf("tbl%0d rsp1_valid", i), 32'(rv1), 32'(tbl[i].ex[1]));
            chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].ex[0]));
            chk($sformatf("tbl%0d rsp_data", i), rsp_data, tbl[i].data);
            chk($sformatf("tbl%0d op_count", i), 32'(op_count), 32'(tbl[i].cnt));
            step();
        end

        // Backpressure: owner holds rsp0_ready low for 5 RESP cycles while req1 waits
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
        step();
        v0 = 1'b0; v1 = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp rsp0_valid", 32'(rv0), 32'd1);
            chk("bp rsp_data", rsp_data, 32'd11);
            chk("bp busy", 32'(busy), 32'd1);
            chk("bp req1_ready", 32'(r1), 32'd0);
            step();
        end
        rr0 = 1'b1; rr1 = 1'b1;
        step();
        #1 chk("bp req1 granted after release", 32'(r1), 32'd1);
        step();
        v1 = 1'b0;
        repeat (3) step();

        // Reset while the operation sits in ISSUE
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; a0 = 32'd8; b0 = 32'd3;
        step();
        v0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst rsp0_valid", 32'(rv0), 32'd0);
        chk("midrst op_count", 32'(op_count), 32'd0);
        chk("midrst alu_a", alu_a, 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        repeat (2) step();

        // Round-robin fairness: six operations with both requesters always valid
        rst = 1'b1; step(); rst = 1'b0;
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
        for (int i = 0; i < 40 && grants.size() < 6; i++) begin
            #1;
            if (r0) grants.push_back(0);
            if (r1) grants.push_back(1);
            step();
        end
        chk("rr grant count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < grants.size() && k < 6; k++)
            chk($sformatf("rr grant %0d", k), 32'(grants[k]), 32'(k % 2));
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) step();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            v0  = ($urandom_range(0, 2) != 0);
            v1  = ($urandom_range(0, 2) != 0);
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            s0 = $urandom_range(0, 1) ? ADD : SUB;
            s1 = $urandom_range(0, 1) ? ADD : SUB;
            step();
        end

        // op_count wrap 16'hFFFF -> 0
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
        step();
        rst = 1'b0;
        force dut.op_count_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.op_count_q;
        step();
        v0 = 1'b1; a0 = 32'd1; b0 = 32'd2; s0 = ADD;
        step();
        v0 = 1'b0;
        repeat (2) step();
        #1 chk("wrap op_count", 32'(op_count), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width of the shared K_ALU_32.
REQ-002 Parameter: SELW, 4, ALU opcode width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-007 reqN_a, reqN_b  input  WIDTH  operands from requester N.
REQ-008 reqN_sel  input  SELW  ALU opcode from requester N.
REQ-009 alu_a, alu_b  output  WIDTH  operands driven to the shared ALU.
REQ-010 alu_sel  output  SELW  opcode driven to the shared ALU.
REQ-011 alu_res  input  WIDTH  combinational ALU result.
REQ-012 rspN_valid  output  1  result for requester N available.
REQ-013 rspN_ready  input  1  requester N consumes result.
REQ-014 rsp_data  output  WIDTH  result, shared by both response channels.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 op_count  output  16  count of completed operations.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and RESP only.
REQ-018 In IDLE, reqN_ready SHALL be high only for the arbitration winner among requesters with reqN_valid high; both low if no valid.
REQ-019 Arbitration SHALL be round-robin: on simultaneous valid, winner is the requester not granted last; single valid wins unconditionally.
REQ-020 The last-grant pointer SHALL update only on handshake (valid && ready).
REQ-021 On handshake in IDLE: latch a, b, sel and owner ID; go to ISSUE.
REQ-022 reqN_ready SHALL be low in ISSUE and RESP; no new request is accepted until return to IDLE.
REQ-023 alu_a, alu_b, alu_sel SHALL be driven from latched registers at all times (stable through ISSUE).
REQ-024 In ISSUE (exactly one cycle), alu_res SHALL be captured into rsp_data; go to RESP.
REQ-025 In RESP, rsp<owner>_valid SHALL be high, the other rspN_valid low, rsp_data held constant.
REQ-026 In RESP, when rsp<owner>_ready is high: increment op_count, go to IDLE; otherwise remain in RESP.
REQ-027 rspN_ready for the non-owner SHALL be ignored.
REQ-028 Latency: handshake at edge t, rsp valid from cycle t+2; minimum 3 cycles per operation.
REQ-029 op_count SHALL wrap 16'hFFFF -> 16'h0000 without flagging.
REQ-030 A request deasserted before handshake SHALL NOT be granted; inputs are not latched without handshake.

Reset
REQ-031 rst high at a rising edge SHALL force IDLE in that cycle regardless of state, discarding any in-flight operation.
REQ-032 Reset values: latched a/b/sel = 0 (so alu_a, alu_b, alu_sel = 0), rsp_data = 0, rspN_valid = 0, busy = 0, op_count = 0, last-grant = 1 (requester 0 wins first tie).
REQ-033 reqN_ready SHALL be low while rst is high.

Verification (bench uses ALU stub alu_res = alu_a + alu_b for sel 4'b1010)
REQ-034 Single request: req0 a=8, b=3, sel=4'b1010 -> req0_ready same cycle, rsp0_valid two cycles later, rsp_data=11, op_count=1 after rsp0_ready.
REQ-035 Tie: req0 (8,3) and req1 (5,5) held valid from reset -> req0 served first (11), then req1 (10), rsp1_valid never with rsp0_valid.
REQ-036 Backpressure: rsp0_ready low 5 cycles -> rsp0_valid and rsp_data=11 held, busy high, req1_ready stays low throughout.
REQ-037 Round-robin fairness: both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-038 Reset mid-operation: rst during ISSUE -> next cycle IDLE, rsp0_valid=0, op_count unchanged at prior value 0, alu_a=0.
REQ-039 Wrap: preload 65535 operations (or force op_count) -> next completion gives op_count=0.
